// File: rtl/vga_timing_pkg.sv
// Shared types and default timing constants for the VGA raster generator.
// Used by vga_timing_gen and vga_axis_counter.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/vga_axis_counter.sv
// Single raster axis counter: counts 0..MAX-1 while enabled and wraps to 0.
// Ports:
//   clk_i    pixel clock
//   rst_i    synchronous active-high reset
//   en_i     advance the count this cycle
//   count_o  registered count
//   next_o   value count_o takes on the next edge (used for registered decode)
//   wrap_o   high when the count wraps on the next edge
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int MAX = 800
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   en_i,
  output coord_t count_o,
  output coord_t next_o,
  output logic   wrap_o
);

  coord_t count_q, count_d;

  assign wrap_o = en_i && (count_q == coord_t'(MAX - 1));

  always_comb begin
    count_d = count_q;
    if (wrap_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source. Free-running pixel/line counters with registered
// blank, hs, vs, line_start and frame_start aligned to DrawX/DrawY.
// Optional feature macro: VGA_FRAME_CNT_EN adds the frame_cnt output.
// Ports:
//   vga_clk      pixel clock, all logic on posedge
//   reset        synchronous active-high reset
//   DrawX/DrawY  current pixel / line
//   blank        1 when the current pixel is visible
//   hs/vs        active-low syncs
//   line_start   pulse on DrawX==0
//   frame_start  pulse on DrawX==0 && DrawY==0
//   frame_cnt    frames completed (VGA_FRAME_CNT_EN only)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        frame_start
);

  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  coord_t x_q, x_next, y_q, y_next;
  logic   h_wrap, v_wrap;

  vga_axis_counter #(.MAX(H_TOT)) u_h_cnt (
    .clk_i   (vga_clk),
    .rst_i   (reset),
    .en_i    (1'b1),
    .count_o (x_q),
    .next_o  (x_next),
    .wrap_o  (h_wrap)
  );

  // The line counter only moves on the pixel that ends a line.
  vga_axis_counter #(.MAX(V_TOT)) u_v_cnt (
    .clk_i   (vga_clk),
    .rst_i   (reset),
    .en_i    (h_wrap),
    .count_o (y_q),
    .next_o  (y_next),
    .wrap_o  (v_wrap)
  );

  logic blank_q, blank_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic ls_q, ls_d;
  logic fs_q, fs_d;

  // Decode from the next count so the registered flags line up with DrawX/DrawY.
  always_comb begin
    blank_d = (x_next < H_VIS_C) && (y_next < V_VIS_C);
    hs_d    = !((x_next >= HS_START) && (x_next < HS_END));
    vs_d    = !((y_next >= VS_START) && (y_next < VS_END));
    ls_d    = h_wrap;
    fs_d    = v_wrap;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (fs_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
